// File: rtl/onewire_byte_ctrl.sv
// onewire_byte_ctrl
//   Byte-level sequencer in front of the bit-level onewire master. Takes
//   reset-pulse / write-byte / read-byte commands and turns each one into a
//   series of one-bit cycles on the master's Avalon MM slave. After each bit
//   cycle it polls the master's completion flag. Each command gets exactly one
//   response. Bits are sent LSB first.
//
// Parameters
//   ADW  Avalon data width (>= 5)
//   PDL  idle clocks between completion polls (1..255)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/ready/op/ovd/data command port; op 00 reset, 01 write, 10 read, 11 reserved
//   rsp_valid/ready/data/err    response port; held until rsp_ready
//   avm_read/write/writedata    requests to the onewire master
//   avm_readdata/waitrequest    bit4 = cycle complete, bit0 = sampled line value
module onewire_byte_ctrl #(
    parameter int ADW = 32,
    parameter int PDL = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic           cmd_ovd,
    input  logic [7:0]     cmd_data,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [7:0]     rsp_data,
    output logic           rsp_err,
    output logic           avm_read,
    output logic           avm_write,
    output logic [ADW-1:0] avm_writedata,
    input  logic [ADW-1:0] avm_readdata,
    input  logic           avm_waitrequest
);

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [7:0] DLY_LAST = 8'(PDL - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DELAY, S_POLL, S_NEXT, S_RESP} state_t;

    state_t     state;
    logic [1:0] op_q;
    logic       ovd_q;
    logic [7:0] data_q;
    logic [7:0] shift_q;
    logic [3:0] cnt;
    logic [7:0] dly;

    // Only the completion flag and the line sample are meaningful.
    logic unused_readdata;
    assign unused_readdata = ^{avm_readdata[ADW-1:5], avm_readdata[3:1]};

    // Control word for one bit cycle: bit0 overdrive, bit1 reset pulse,
    // bit2 the data slot value (a read slot is a write-1 slot).
    function automatic logic [ADW-1:0] slot_word(input logic [1:0] op, input logic ovd,
                                                 input logic [7:0] data, input logic [2:0] idx);
        logic [ADW-1:0] w;
        w    = '0;
        w[0] = ovd;
        w[1] = (op == OP_RST);
        w[2] = (op == OP_RD) || ((op == OP_WR) && data[idx]);
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= 8'h00;
            rsp_err       <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            op_q          <= 2'b00;
            ovd_q         <= 1'b0;
            data_q        <= 8'h00;
            shift_q       <= 8'h00;
            cnt           <= 4'd0;
            dly           <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        ovd_q     <= cmd_ovd;
                        data_q    <= cmd_data;
                        shift_q   <= 8'h00;
                        cnt       <= 4'd0;
                        if (cmd_op == OP_RSV) begin
                            // Reserved op: answer immediately, never touch the bus.
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 8'h00;
                        end else begin
                            state         <= S_ISSUE;
                            avm_write     <= 1'b1;
                            avm_writedata <= slot_word(cmd_op, cmd_ovd, cmd_data, 3'd0);
                        end
                    end
                end
                S_ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        dly       <= 8'd0;
                        state     <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    // PDL quiet clocks, then raise the poll.
                    if (dly == DLY_LAST) begin
                        avm_read <= 1'b1;
                        state    <= S_POLL;
                    end else begin
                        dly <= dly + 8'd1;
                    end
                end
                S_POLL: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (avm_readdata[4]) begin
                            shift_q[cnt[2:0]] <= avm_readdata[0];
                            state             <= S_NEXT;
                        end else begin
                            dly   <= 8'd0;
                            state <= S_DELAY;
                        end
                    end
                end
                S_NEXT: begin
                    rsp_err <= 1'b0;
                    if (op_q == OP_RST) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {7'b0, shift_q[0]};
                    end else begin
                        cnt <= cnt + 4'd1;
                        // cnt == 7 here means the incremented count reaches 8.
                        if (cnt == 4'd7) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= (op_q == OP_WR) ? data_q : shift_q;
                        end else begin
                            state         <= S_ISSUE;
                            avm_write     <= 1'b1;
                            avm_writedata <= slot_word(op_q, ovd_q, data_q, cnt[2:0] + 3'd1);
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_byte_ctrl.sv
// Bench for onewire_byte_ctrl: directed commands against an Avalon slave model
// with configurable wait states and not-yet-complete polls. A single monitor
// process at the falling edge checks bus rules, handshake timing and the
// per-command expectations produced by a byte-level model.
module tb_onewire_byte_ctrl;

    localparam int ADW = 32;
    localparam int PDL = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic           cmd_ovd;
    logic [7:0]     cmd_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [7:0]     rsp_data;
    logic           rsp_err;
    logic           avm_read;
    logic           avm_write;
    logic [ADW-1:0] avm_writedata;
    logic [ADW-1:0] readdata;
    logic           waitreq;

    onewire_byte_ctrl #(.ADW(ADW), .PDL(PDL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ovd(cmd_ovd), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(readdata), .avm_waitrequest(waitreq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration (set by stimulus)
    int         sl_ws  = 0;
    int         sl_ncp = 0;
    logic [7:0] sl_byte = 8'hFF;

    // monitor state
    logic [ADW-1:0] exp_wr[$];
    logic [8:0]     exp_rsp[$];
    logic [ADW-1:0] wr_log[$];
    int   cyc = 0, lat = 0, last_lat = 0, idle_run = 0;
    int   ws_cnt = 0, nc_cnt = 0, bit_i = 0, n_polls = 0;
    int   n_cmd_hs = 0, n_rsp = 0, cmd_hs_cyc = 0, rsp_hs_cyc = 0;
    bit   busy = 0, post_rst = 0, first_wr = 0;
    logic [1:0] cur_op = 2'b00;
    logic [7:0] last_rsp = 8'h00;
    logic       last_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Byte-level model: bit cycles the command must produce and its response.
    // exp_rsp bit8 = error flag; data is only checked when no error.
    task automatic model(input logic [1:0] op, input logic ovd, input logic [7:0] d);
        logic [8:0] r;
        case (op)
            2'b00: begin
                exp_wr.push_back(32'h2 | 32'(ovd));
                r = {1'b0, 7'b0, sl_byte[0]};
            end
            2'b01: begin
                for (int i = 0; i < 8; i++) exp_wr.push_back((d[i] ? 32'h4 : 32'h0) | 32'(ovd));
                r = {1'b0, d};
            end
            2'b10: begin
                for (int i = 0; i < 8; i++) exp_wr.push_back(32'h4 | 32'(ovd));
                r = {1'b0, sl_byte};
            end
            default: r = {1'b1, 8'h00};
        endcase
        exp_rsp.push_back(r);
    endtask

    // Monitor + slave model, all at the falling edge.
    initial begin
        logic           p_wr, p_rd, p_wq, p_rv, p_rr, p_re;
        logic [ADW-1:0] p_wd;
        logic [7:0]     p_rd8;
        logic [8:0]     er;
        logic [31:0]    rdv;
        p_wr = 0; p_rd = 0; p_wq = 0; p_rv = 0; p_rr = 0; p_re = 0; p_wd = '0; p_rd8 = 0;
        waitreq = 1'b0;
        readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy = 0; post_rst = 0; idle_run = 0;
                exp_wr.delete(); exp_rsp.delete();
                ws_cnt = 0; nc_cnt = 0; bit_i = 0;
                waitreq = 1'b0; readdata = '0;
            end else begin
                // transfers that completed on the last rising edge
                if (p_wr && !p_wq) begin
                    chk("wr_deassert", avm_write, 0);
                    chk("wr_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) chk("wr_data", p_wd, exp_wr.pop_front());
                    wr_log.push_back(p_wd);
                    nc_cnt = 0;
                end
                if (p_rd && !p_wq) begin
                    chk("rd_deassert", avm_read, 0);
                    n_polls++;
                    if (nc_cnt < sl_ncp) nc_cnt++;
                    else bit_i++;
                end
                // per-cycle rules
                chk("rd_wr_excl", avm_read & avm_write, 0);
                if ((p_wr || p_rd) && p_wq)
                    chk("stall_hold", {avm_read, avm_write, avm_writedata}, {p_rd, p_wr, p_wd});
                chk("cmd_ready", cmd_ready, post_rst && !busy);
                if (p_rv && !p_rr)
                    chk("rsp_hold", {rsp_valid, rsp_err, rsp_data}, {1'b1, p_re, p_rd8});
                if (!busy) begin
                    chk("idle_req", avm_read | avm_write, 0);
                    chk("idle_rsp", rsp_valid, 0);
                end else if (cur_op == 2'b11) begin
                    chk("rsv_req", avm_read | avm_write, 0);
                end
                if (avm_read && !p_rd) chk("poll_gap", idle_run, PDL);
                if (avm_write && !p_wr && !first_wr) chk("bit_gap", idle_run, 1);
                if (avm_write) first_wr = 0;
                idle_run = (avm_read || avm_write) ? 0 : idle_run + 1;
                if (busy) begin
                    lat++;
                    if (rsp_valid && !p_rv) last_lat = lat;
                end
                // handshakes taking effect on the next rising edge
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_expected", exp_rsp.size() != 0, 1);
                    if (exp_rsp.size() != 0) begin
                        er = exp_rsp.pop_front();
                        chk("rsp_err", rsp_err, er[8]);
                        if (!er[8]) chk("rsp_data", rsp_data, er[7:0]);
                    end
                    chk("wr_all_done", exp_wr.size(), 0);
                    busy = 0; rsp_hs_cyc = cyc; n_rsp++;
                    last_rsp = rsp_data; last_err = rsp_err;
                end
                if (cmd_valid && cmd_ready) begin
                    model(cmd_op, cmd_ovd, cmd_data);
                    busy = 1; cur_op = cmd_op; lat = 1; first_wr = 1;
                    cmd_hs_cyc = cyc; n_cmd_hs++;
                    bit_i = 0; nc_cnt = 0; n_polls = 0;
                    wr_log.delete();
                end
                post_rst = 1;
                // slave: waitrequest for sl_ws clocks per transfer, then complete
                if (avm_read || avm_write) begin
                    if (ws_cnt < sl_ws) begin waitreq = 1'b1; ws_cnt++; end
                    else begin waitreq = 1'b0; ws_cnt = 0; end
                end else begin
                    waitreq = 1'b0; ws_cnt = 0;
                end
                rdv    = $urandom;   // junk in the ignored bits
                rdv[4] = (nc_cnt >= sl_ncp);
                rdv[0] = sl_byte[bit_i % 8];
                readdata = rdv;
            end
            p_wr = avm_write; p_rd = avm_read; p_wq = waitreq; p_wd = avm_writedata;
            p_rv = rsp_valid; p_rr = rsp_ready; p_rd8 = rsp_data; p_re = rsp_err;
        end
    end

    task automatic send(input logic [1:0] op, input logic ovd, input logic [7:0] d);
        int n0;
        n0 = n_cmd_hs;
        cmd_op = op; cmd_ovd = ovd; cmd_data = d; cmd_valid = 1'b1;
        for (int i = 0; i < 200 && n_cmd_hs == n0; i++) begin @(posedge clk); #2; end
        chk("cmd_accepted", n_cmd_hs > n0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n0, input int budget);
        for (int i = 0; i < budget && n_rsp == n0; i++) begin @(posedge clk); #2; end
        chk("rsp_arrived", n_rsp > n0, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_write"}, avm_write, 0);
        chk({tag, "_avm_wd"}, avm_writedata, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, c0;
        int pat2[8];
        pat2 = '{1, 0, 1, 0, 0, 1, 0, 1};
        cmd_valid = 0; cmd_op = 0; cmd_ovd = 0; cmd_data = 0; rsp_ready = 1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst0");
        @(posedge clk); #2; rst_n = 1;
        repeat (2) begin @(posedge clk); #2; end

        // 1: reset pulse, presence seen (line low)
        sl_byte = 8'hFE; r0 = n_rsp;
        send(2'b00, 1'b0, 8'h00); wait_rsp(r0, 500);
        chk("t1_nwr", wr_log.size(), 1);
        chk("t1_wd", wr_log[0], 32'h2);
        chk("t1_rsp", last_rsp, 8'h00);
        chk("t1_err", last_err, 0);
        chk("t1_lat", last_lat, PDL + 5);
        chk("t1_polls", n_polls, 1);

        // 1b: reset pulse, overdrive, no presence
        sl_byte = 8'h01; r0 = n_rsp;
        send(2'b00, 1'b1, 8'h00); wait_rsp(r0, 500);
        chk("t1b_wd", wr_log[0], 32'h3);
        chk("t1b_rsp", last_rsp, 8'h01);

        // 2: write 0xA5
        sl_byte = 8'h00; r0 = n_rsp;
        send(2'b01, 1'b0, 8'hA5); wait_rsp(r0, 1000);
        chk("t2_nwr", wr_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_bit", wr_log[i][2], pat2[i]);
        chk("t2_rsp", last_rsp, 8'hA5);
        chk("t2_lat", last_lat, 66);

        // 3: read, slave returns 0x3C
        sl_byte = 8'h3C; r0 = n_rsp;
        send(2'b10, 1'b0, 8'h77); wait_rsp(r0, 1000);
        for (int i = 0; i < 8; i++) chk("t3_wd", wr_log[i], 32'h4);
        chk("t3_rsp", last_rsp, 8'h3C);
        chk("t3_polls", n_polls, 8);

        // 4: 5 wait states everywhere, 3 incomplete polls per bit, overdrive
        sl_ws = 5; sl_ncp = 3; sl_byte = 8'h3C; r0 = n_rsp;
        send(2'b10, 1'b1, 8'h00); wait_rsp(r0, 3000);
        for (int i = 0; i < 8; i++) chk("t4_wd", wr_log[i], 32'h5);
        chk("t4_rsp", last_rsp, 8'h3C);
        chk("t4_polls", n_polls, 32);

        // 4b: stalled write with overdrive
        r0 = n_rsp;
        send(2'b01, 1'b1, 8'h0F); wait_rsp(r0, 3000);
        chk("t4b_rsp", last_rsp, 8'h0F);
        chk("t4b_wd7", wr_log[7], 32'h1);
        sl_ws = 0; sl_ncp = 0;

        // 5: response back-pressure with next command waiting
        rsp_ready = 0; r0 = n_rsp;
        send(2'b01, 1'b0, 8'h5A);
        cmd_op = 2'b10; cmd_ovd = 1'b0; cmd_data = 8'h00; cmd_valid = 1'b1; sl_byte = 8'h96;
        for (int i = 0; i < 1000 && !rsp_valid; i++) begin @(posedge clk); #2; end
        chk("t5_rsp_valid", rsp_valid, 1);
        repeat (10) begin @(posedge clk); #2; end
        c0 = n_cmd_hs;
        rsp_ready = 1;
        for (int i = 0; i < 50 && n_cmd_hs == c0; i++) begin @(posedge clk); #2; end
        cmd_valid = 1'b0;
        chk("t5_accepted", n_cmd_hs > c0, 1);
        chk("t5_gap", cmd_hs_cyc - rsp_hs_cyc, 1);
        chk("t5_rsp_a", last_rsp, 8'h5A);
        wait_rsp(r0 + 1, 1000);
        chk("t5_rsp_b", last_rsp, 8'h96);

        // 6: reset during bit 3 of a write, then reserved op
        r0 = n_rsp;
        send(2'b01, 1'b0, 8'hC3);
        for (int i = 0; i < 500 && wr_log.size() < 4; i++) begin @(posedge clk); #2; end
        chk("t6_in_bit3", wr_log.size() >= 4, 1);
        rst_n = 0;
        @(negedge clk);
        chk_reset("t6");
        @(posedge clk); #2; rst_n = 1;
        repeat (2) begin @(posedge clk); #2; end
        chk("t6_dropped", n_rsp, r0);
        r0 = n_rsp;
        send(2'b11, 1'b0, 8'hFF); wait_rsp(r0, 100);
        chk("t6_err", last_err, 1);
        chk("t6_lat", last_lat, 2);
        chk("t6_nwr", wr_log.size(), 0);
        chk("t6_polls", n_polls, 0);
        repeat (3) begin @(posedge clk); #2; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
